// File: rtl/muldiv_sched.sv
// Execute-stage scheduler for the shared mul/div unit of the dual-issue pipe.
// Grants master then slave, counts latency, strobes HI/LO capture per slot.
module muldiv_sched #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic clk,
  input  logic resetn,
  input  logic req1_i,
  input  logic req2_i,
  input  logic div1_i,
  input  logic div2_i,
  input  logic sign1_i,
  input  logic sign2_i,
  input  logic pipe_stall_i,
  input  logic flush_i,
  output logic alu_stallE,
  output logic start_o,
  output logic sel_o,
  output logic div_o,
  output logic sign_o,
  output logic abort_o,
  output logic cap1_o,
  output logic cap2_o
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          done1_q, done1_d;
  logic          done2_q, done2_d;
  logic          pend1, pend2;
  logic          live;
  logic          clr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      done1_q <= done1_d;
      done2_q <= done2_d;
    end
  end

  // resetn gates the stall so a held request is not seen during reset
  always_comb begin
    pend1      = req1_i & ~done1_q;
    pend2      = req2_i & ~done2_q;
    live       = resetn & ~flush_i;
    alu_stallE = live & (pend1 | pend2);
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    start_o    = 1'b0;
    sel_o      = 1'b0;
    div_o      = 1'b0;
    sign_o     = 1'b0;
    abort_o    = 1'b0;
    cap1_o     = 1'b0;
    cap2_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (live & (pend1 | pend2)) begin
          start_o = 1'b1;
          sel_o   = ~pend1;
          div_o   = pend1 ? div1_i : div2_i;
          sign_o  = pend1 ? sign1_i : sign2_i;
          cnt_d   = div_o ? DIV_LD : MUL_LD;
          sel_d   = sel_o;
          state_d = RUN;
        end
      end
      RUN: begin
        sel_o = sel_q;
        if (flush_i) begin
          abort_o = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          cap1_o  = ~sel_q;
          cap2_o  = sel_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  // done flags survive a foreign stall so a finished slot is not relaunched
  always_comb begin
    clr     = flush_i | (~alu_stallE & ~pipe_stall_i);
    done1_d = clr ? 1'b0 : (done1_q | cap1_o);
    done2_d = clr ? 1'b0 : (done2_q | cap2_o);
  end

endmodule
